// File: rtl/seq_accum_if.sv
// seq_accum_if: start/gather/done request bus and published-result bus for seq_accum_src
interface seq_accum_if #(parameter int W = 32);
    logic         start;
    logic         gather;
    logic         done;
    logic [W-1:0] data;
    logic         busy;
    logic         valid;
    logic [W-1:0] data_out;
    modport master (output start, gather, done, data, input busy, valid, data_out);
    modport slave  (input start, gather, done, data, output busy, valid, data_out);
endinterface

// File: rtl/seq_accum_src.sv
// seq_accum_src: start + BEATS gather accumulator, published on done; signed W-bit sums.
// Define SEQ_ACCUM_SAT_EN to saturate each addition instead of wrapping.
module seq_accum_src #(
    parameter int W      = 32,
    parameter int OFFSET = 2,
    parameter int BEATS  = 2
) (
    input logic          clk,
    input logic          rst_n,
    seq_accum_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, WAIT_D = 2'd2;
    logic [1:0]   state;
    logic [W-1:0] acc;
    logic [7:0]   count;
    function automatic logic [W-1:0] add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
`ifdef SEQ_ACCUM_SAT_EN
        // overflow only when operands share a sign that the sum lost
        if (a[W-1] == b[W-1] && s[W-1] != a[W-1])
            s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return s;
    endfunction
    assign bus.busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            bus.valid    <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    acc   <= add(bus.data, W'(OFFSET));
                    count <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (bus.gather) begin
                    acc   <= add(acc, bus.data);
                    count <= count + 8'd1;
                    state <= (count == 8'(BEATS - 1)) ? WAIT_D : ACCUM;
                end
                WAIT_D: if (bus.done) begin
                    bus.data_out <= acc;
                    bus.valid    <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_accum_src.md
SEQ_ACCUM_SRC -- requirements
Module: seq_accum_src

Interface
REQ-001 Parameter W, default 32: data and accumulator width in bits, two's-complement signed.
REQ-002 Parameter OFFSET, default 2: signed constant added to the first data beat.
REQ-003 Parameter BEATS, default 2, legal 1..255: number of gather beats per transaction.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to open a transaction; data sampled with it.
REQ-007 gather  input  1  strobe marking one data beat to accumulate.
REQ-008 done  input  1  request to publish the accumulated result.
REQ-009 data  input  W  operand, sampled on start or gather.
REQ-010 busy  output  1  high while a transaction is open.
REQ-011 valid  output  1  one-cycle pulse: data_out was updated on the previous edge.
REQ-012 data_out  output  W  last published result; holds between transactions.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, WAIT_D; busy = (state != IDLE), combinational from state.
REQ-014 IDLE and start=1: acc <= data + OFFSET, beat count <= 0, go to ACCUM; gather and done ignored.
REQ-015 ACCUM and gather=1: acc <= acc + data, count increments; on the BEATS-th beat go to WAIT_D.
REQ-016 ACCUM with gather=0: hold acc, count and state; start and done ignored.
REQ-017 WAIT_D and done=1: data_out <= acc, valid <= 1, go to IDLE in the same edge.
REQ-018 WAIT_D with done=0: hold; start and gather ignored.
REQ-019 valid SHALL be high for exactly one cycle per published result and low otherwise.
REQ-020 start during a busy cycle SHALL be dropped, not queued.
REQ-021 Start is accepted no earlier than the cycle after the done edge, so minimum transaction spacing is BEATS+2 cycles.
REQ-022 Without the Configuration feature, additions SHALL wrap modulo 2^W.
REQ-023 data_out = (data_start + OFFSET + sum of BEATS gathered data) under the active arithmetic rule.
REQ-024 Gather and done asserted together in the final ACCUM beat: gather is taken and done is ignored; a later done is required.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy 0, valid 0, data_out 0, acc 0, count 0, independent of clk.
REQ-026 Reset mid-transaction SHALL discard the partial sum; no valid pulse is produced.
REQ-027 The first edge after rst_n rises SHALL behave as an IDLE edge.

Configuration
REQ-028 Macro SEQ_ACCUM_SAT_EN defined: each addition SHALL saturate to the signed W-bit max or min on overflow instead of wrapping.
REQ-029 Macro SEQ_ACCUM_SAT_EN undefined: wrap-around per REQ-022; saturation logic absent.

Verification
REQ-030 Defaults, data=1: start, gather x2, done -> data_out=5, valid high one cycle after the done edge, busy low same cycle.
REQ-031 Start pulsed during ACCUM with data=100 -> result unchanged (5 for REQ-030 stimulus), no second transaction.
REQ-032 Done held through ACCUM with gather on the last beat -> no publish until WAIT_D sees done; data_out stays 0 until then.
REQ-033 rst_n low after the first gather -> busy=0 asynchronously, data_out=0, no valid; a new start then yields correct 5.
REQ-034 data=0x7FFFFFFF on start and both beats: without SEQ_ACCUM_SAT_EN data_out=0x7FFFFFFF+0x7FFFFFFF*2+2 mod 2^32=0x7FFFFFFF; with it data_out=0x7FFFFFFF.
REQ-035 BEATS=1, data=-3: start, gather (data=-3), done -> data_out=-4 (0xFFFFFFFC).
